// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel gradient path: pixel/gradient widths,
// the saturation ceiling and the default frame geometry.
package sobel_pkg;

    localparam int DATA_W         = 8;
    localparam int GRAD_W         = DATA_W + 3;
    localparam int MAG_MAX        = (1 << DATA_W) - 1;
    localparam int DEF_IMG_WIDTH  = 8;
    localparam int DEF_IMG_HEIGHT = 8;

endpackage

// File: rtl/sobel_window_gradient_kernel.sv
// Purely combinational 3x3 Sobel kernel producing signed Gx/Gy.
// The centre pixel carries zero weight in both directions, so it is not a port.
module sobel_kernel #(
    parameter int DATA_W    = sobel_pkg::DATA_W,
    parameter int GRAD_BITS = DATA_W + 3
) (
    input  logic [DATA_W-1:0]           i_p00,
    input  logic [DATA_W-1:0]           i_p01,
    input  logic [DATA_W-1:0]           i_p02,
    input  logic [DATA_W-1:0]           i_p10,
    input  logic [DATA_W-1:0]           i_p12,
    input  logic [DATA_W-1:0]           i_p20,
    input  logic [DATA_W-1:0]           i_p21,
    input  logic [DATA_W-1:0]           i_p22,
    output logic signed [GRAD_BITS-1:0] o_gx,
    output logic signed [GRAD_BITS-1:0] o_gy
);

    function automatic logic signed [GRAD_BITS-1:0] ext(input logic [DATA_W-1:0] p);
        return $signed(GRAD_BITS'(p));
    endfunction

    assign o_gx = ext(i_p02) + (ext(i_p12) <<< 1) + ext(i_p22)
                - ext(i_p00) - (ext(i_p10) <<< 1) - ext(i_p20);

    assign o_gy = ext(i_p20) + (ext(i_p21) <<< 1) + ext(i_p22)
                - ext(i_p00) - (ext(i_p01) <<< 1) - ext(i_p02);

endmodule

// File: rtl/sobel_window_gradient.sv
// 3x3 window builder plus two-stage |Gx|+|Gy| pipeline for the Sobel edge path;
// emits one saturated magnitude per interior pixel with a frame-end pulse.
module sobel_window_gradient
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_W     = sobel_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Enable,
    input  logic [DATA_W-1:0] Row0In,
    input  logic [DATA_W-1:0] Row1In,
    input  logic [DATA_W-1:0] Row2In,
    output logic [DATA_W-1:0] DataOut,
    output logic              ValidOut,
    output logic              FrameDone
);

    localparam int GRAD_BITS = DATA_W + 3;
    localparam int COL_W     = $clog2(IMG_WIDTH);
    localparam int ROW_W     = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [DATA_W-1:0] SAT_MAX  = '1;

    logic [DATA_W-1:0]           r_win [3][3];
    logic [COL_W-1:0]            r_col;
    logic [ROW_W-1:0]            r_row;
    logic                        r_tok;
    logic                        r_tokLast;
    logic                        r_s1Valid;
    logic                        r_s1Last;
    logic signed [GRAD_BITS-1:0] r_gx;
    logic signed [GRAD_BITS-1:0] r_gy;
    logic [DATA_W-1:0]           r_dataOut;
    logic                        r_validOut;
    logic                        r_frameDone;

    logic signed [GRAD_BITS-1:0] w_gx;
    logic signed [GRAD_BITS-1:0] w_gy;
    logic [GRAD_BITS-1:0]        w_absGx;
    logic [GRAD_BITS-1:0]        w_absGy;
    logic [GRAD_BITS-1:0]        w_mag;
    logic [DATA_W-1:0]           w_sat;
    logic                        w_inside;
    logic                        w_lastPix;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
        end else if (Enable) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= Row2In;
            r_win[1][2] <= Row1In;
            r_win[2][2] <= Row0In;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_col <= '0;
            r_row <= '0;
        end else if (Enable) begin
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Counters still hold the coordinates of the pixel being accepted this edge.
    assign w_inside  = (r_col >= COL_W'(2)) && (r_row >= ROW_W'(2));
    assign w_lastPix = (r_col == LAST_COL) && (r_row == LAST_ROW);

    sobel_kernel #(
        .DATA_W    (DATA_W),
        .GRAD_BITS (GRAD_BITS)
    ) u_kernel (
        .i_p00 (r_win[0][0]),
        .i_p01 (r_win[0][1]),
        .i_p02 (r_win[0][2]),
        .i_p10 (r_win[1][0]),
        .i_p12 (r_win[1][2]),
        .i_p20 (r_win[2][0]),
        .i_p21 (r_win[2][1]),
        .i_p22 (r_win[2][2]),
        .o_gx  (w_gx),
        .o_gy  (w_gy)
    );

    assign w_absGx = r_gx[GRAD_BITS-1] ? GRAD_BITS'(-r_gx) : GRAD_BITS'(r_gx);
    assign w_absGy = r_gy[GRAD_BITS-1] ? GRAD_BITS'(-r_gy) : GRAD_BITS'(r_gy);
    assign w_mag   = w_absGx + w_absGy;
    assign w_sat   = (w_mag > GRAD_BITS'(SAT_MAX)) ? SAT_MAX : w_mag[DATA_W-1:0];

    // Tokens advance every cycle regardless of Enable so a stall still drains.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tok       <= 1'b0;
            r_tokLast   <= 1'b0;
            r_s1Valid   <= 1'b0;
            r_s1Last    <= 1'b0;
            r_gx        <= '0;
            r_gy        <= '0;
            r_dataOut   <= '0;
            r_validOut  <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_tok       <= Enable && w_inside;
            r_tokLast   <= Enable && w_lastPix;
            r_s1Valid   <= r_tok;
            r_s1Last    <= r_tok && r_tokLast;
            if (r_tok) begin
                r_gx <= w_gx;
                r_gy <= w_gy;
            end
            if (r_s1Valid)
                r_dataOut <= w_sat;
            r_validOut  <= r_s1Valid;
            r_frameDone <= r_s1Valid && r_s1Last;
        end
    end

    assign DataOut   = r_dataOut;
    assign ValidOut  = r_validOut;
    assign FrameDone = r_frameDone;

endmodule

// File: tb/tb_sobel_window_gradient.sv
// Self-checking bench for sobel_window_gradient: drives whole frames and compares
// every output cycle against a window-arithmetic reference with due-cycle timing.
module tb_sobel_window_gradient;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;

    logic          CLK    = 1'b0;
    logic          RST    = 1'b1;
    logic          Enable = 1'b0;
    logic [DW-1:0] Row0In = '0;
    logic [DW-1:0] Row1In = '0;
    logic [DW-1:0] Row2In = '0;
    logic [DW-1:0] DataOut;
    logic          ValidOut;
    logic          FrameDone;

    sobel_window_gradient #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (DW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Enable    (Enable),
        .Row0In    (Row0In),
        .Row1In    (Row1In),
        .Row2In    (Row2In),
        .DataOut   (DataOut),
        .ValidOut  (ValidOut),
        .FrameDone (FrameDone)
    );

    always #5 CLK = ~CLK;

    int cycleCnt = 0;
    always @(posedge CLK) cycleCnt++;

    typedef struct {
        int due;
        int data;
        bit last;
    } expT;

    expT expQ[$];
    int  checkCount = 0;
    int  errorCount = 0;
    int  mdlRow     = 0;
    int  mdlCol     = 0;
    int  lastData   = 0;
    int  validCount = 0;
    int  fdCount    = 0;
    int  s0[W];
    int  s1[W];
    int  s2[W];
    int  randImg[3][W*H];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycleCnt);
        end
    endtask

    // Window row 0 is the oldest line (Row2In stream), row 2 the current line.
    function automatic int winPix(input int rr, input int cc);
        if (rr == 0) return s2[cc];
        if (rr == 1) return s1[cc];
        return s0[cc];
    endfunction

    task automatic modelAccept(input int a0, input int a1, input int a2);
        int  b, gx, gy, mag;
        expT e;
        s0[mdlCol] = a0;
        s1[mdlCol] = a1;
        s2[mdlCol] = a2;
        if (mdlRow >= 2 && mdlCol >= 2) begin
            b   = mdlCol - 2;
            gx  = (winPix(0, b+2) + 2*winPix(1, b+2) + winPix(2, b+2))
                - (winPix(0, b)   + 2*winPix(1, b)   + winPix(2, b));
            gy  = (winPix(2, b) + 2*winPix(2, b+1) + winPix(2, b+2))
                - (winPix(0, b) + 2*winPix(0, b+1) + winPix(0, b+2));
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            e.due  = cycleCnt + 3;
            e.data = (mag > 255) ? 255 : mag;
            e.last = (mdlRow == H-1) && (mdlCol == W-1);
            expQ.push_back(e);
        end
        mdlCol++;
        if (mdlCol == W) begin
            mdlCol = 0;
            mdlRow = (mdlRow == H-1) ? 0 : mdlRow + 1;
        end
    endtask

    task automatic applyStimulus(input bit en, input int a0, input int a1, input int a2);
        @(negedge CLK);
        Enable = en;
        Row0In = a0[DW-1:0];
        Row1In = a1[DW-1:0];
        Row2In = a2[DW-1:0];
        if (en) modelAccept(a0, a1, a2);
    endtask

    // Every output cycle is checked: valid only on a token's due cycle, data held otherwise.
    always @(negedge CLK) begin : monitor
        expT e;
        bit  expV;
        expV = (expQ.size() > 0) && (expQ[0].due == cycleCnt);
        if (ValidOut) validCount++;
        if (FrameDone) fdCount++;
        checkOutput("validOut", int'(ValidOut), expV ? 1 : 0);
        if (expV) begin
            e = expQ.pop_front();
            checkOutput("dataOut", int'(DataOut), e.data);
            checkOutput("frameDone", int'(FrameDone), e.last ? 1 : 0);
            lastData = e.data;
        end else begin
            checkOutput("frameDoneIdle", int'(FrameDone), 0);
            checkOutput("dataHold", int'(DataOut), lastData);
        end
    end

    function automatic int pix(input int mode, input int stream, input int idx);
        case (mode)
            0:       return 100;
            1:       return ((idx % W) < 4) ? 0 : 255;
            2:       return 10 * (idx % W);
            default: return randImg[stream][idx];
        endcase
    endfunction

    task automatic doMidReset();
        @(posedge CLK);
        #2;
        RST    = 1'b1;
        Enable = 1'b0;
        expQ.delete();
        mdlRow   = 0;
        mdlCol   = 0;
        lastData = 0;
        #1;
        checkOutput("midRstData", int'(DataOut), 0);
        checkOutput("midRstValid", int'(ValidOut), 0);
        checkOutput("midRstFrameDone", int'(FrameDone), 0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic runFrame(input int mode, input bit toggle, input bit randGaps,
                            input int stallAt, input int resetAt,
                            input int expValid, input int expFd);
        validCount = 0;
        fdCount    = 0;
        for (int idx = 0; idx < W*H; idx++) begin
            while ((toggle && ((cycleCnt / 40) % 2 == 1)) ||
                   (randGaps && $urandom_range(0, 3) == 0))
                applyStimulus(1'b0, 0, 0, 0);
            applyStimulus(1'b1, pix(mode, 0, idx), pix(mode, 1, idx), pix(mode, 2, idx));
            if (idx == stallAt) begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(1'b0, 0, 0, 0);
                    checkOutput("latencyValid", int'(ValidOut), (i == 2) ? 1 : 0);
                end
            end
            if (idx == resetAt) begin
                doMidReset();
                break;
            end
        end
        repeat (5) applyStimulus(1'b0, 0, 0, 0);
        checkOutput("validCount", validCount, expValid);
        checkOutput("frameDoneCount", fdCount, expFd);
    endtask

    task automatic newRandomImage();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < W*H; i++)
                randImg[s][i] = int'($urandom_range(0, 255));
    endtask

    initial begin
        #1;
        checkOutput("rstData", int'(DataOut), 0);
        checkOutput("rstValid", int'(ValidOut), 0);
        checkOutput("rstFrameDone", int'(FrameDone), 0);
        @(negedge CLK);
        RST = 1'b0;

        runFrame(0, 1'b0, 1'b0, -1, -1, 36, 1);
        runFrame(1, 1'b0, 1'b0, -1, -1, 36, 1);
        runFrame(2, 1'b0, 1'b0, -1, -1, 36, 1);

        newRandomImage();
        runFrame(3, 1'b0, 1'b0, 2*W + 2, -1, 36, 1);
        runFrame(3, 1'b1, 1'b0, -1, -1, 36, 1);

        newRandomImage();
        runFrame(3, 1'b0, 1'b1, -1, -1, 36, 1);

        newRandomImage();
        runFrame(3, 1'b0, 1'b0, -1, 4*W + 3, 12, 0);
        newRandomImage();
        runFrame(3, 1'b0, 1'b0, -1, -1, 36, 1);

        checkOutput("queueDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sobel_window_gradient.md
Name: sobel_window_gradient

Overview:
- Downstream consumer of the 8-cell line-delay FIFO chain in the Sobel edge path.
- Takes three vertically aligned pixels per column (current line, 1-line-delayed, 2-line-delayed) and builds a 3x3 window in shift registers.
- Computes |Gx|+|Gy| saturated to 8 bits, with valid and end-of-frame flags, for the output writer.

Parameters:
- IMG_WIDTH, 8, pixels per line (matches FIFO depth); minimum 3.
- IMG_HEIGHT, 8, lines per frame; minimum 3.
- DATA_W, 8, pixel width in bits.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- Enable  input  1  column accept; Row*In sampled on CLK edges where Enable=1.
- Row0In  input  DATA_W  current-line pixel (bottom row of window).
- Row1In  input  DATA_W  FIFO output, 1 line delayed (middle row).
- Row2In  input  DATA_W  2 lines delayed (top row).
- DataOut  output  DATA_W  gradient magnitude for the window centre.
- ValidOut  output  1  DataOut valid this cycle.
- FrameDone  output  1  one-cycle pulse with the final valid output of a frame.

Behaviour:
- Reset: all window regs, counters and pipeline regs cleared to 0; DataOut=0, ValidOut=0, FrameDone=0. Async assert; reset mid-frame discards partial frame; next accepted column is col 0, row 0.
- Window: on Enable edge, columns shift left (c0<=c1, c1<=c2, c2<=new Row2/Row1/Row0). Naming pRC: R=0 top (Row2In), R=2 bottom (Row0In); C=0 oldest, C=2 newest.
- Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1, advanced on Enable edges only; col wraps to 0 and increments row; after (H-1,W-1) both wrap to 0.
- Window valid token: generated on an Enable edge whose accepted pixel has col>=2 and row>=2, i.e. window fully inside the image. No output for border pixels. Exactly (W-2)*(H-2) tokens per frame.
- Stage 1 (edge after token): Gx = (p02+2*p12+p22) - (p00+2*p10+p20); Gy = (p20+2*p21+p22) - (p00+2*p01+p02). Signed, DATA_W+3 bits (range +/-1020 for 8-bit).
- Stage 2 (next edge): mag = |Gx|+|Gy| (unsigned, DATA_W+3 bits, max 2040); DataOut = mag > 2^DATA_W-1 ? 2^DATA_W-1 : mag.
- Latency: column accepted at edge k -> DataOut/ValidOut registered at edge k+2, held one cycle.
- ValidOut deasserts the cycle after unless a new token follows; DataOut holds its last value when ValidOut=0.
- Stall: Enable=0 freezes window and counters; tokens already in stages 1-2 still drain, so output during a stall is legal.
- Back-to-back Enable: one result per cycle, no bubbles.
- FrameDone: token of pixel (H-1,W-1) carries a last flag down the pipe; FrameDone=1 in the same cycle as that ValidOut.
- Row0In/Row1In/Row2In alignment is the upstream FIFOs' responsibility; the block does not check it.

Decomposition:
- Shared package sobel_pkg: DATA_W, GRAD_W = DATA_W+3, MAG_MAX = 2^DATA_W-1, default IMG_WIDTH/IMG_HEIGHT.
- One sub-module: sobel_kernel. Purely combinational Gx/Gy from the nine window pixels, reused by any later direction/threshold stage.
- Counters, window registers and pipeline stay in the top module.

Test Plan:
- Uniform image, all pixels 100, Enable held 1, 8x8 -> exactly 36 ValidOut pulses, all DataOut=0; FrameDone once, coincident with the 36th.
- Vertical step, cols 0-3 = 0, cols 4-7 = 255 -> windows straddling the step: Gx=1020, DataOut=255 (saturated); flat windows give 0.
- Horizontal ramp, pixel = 10*col, all rows -> every valid window Gx=80, Gy=0, DataOut=80.
- Latency: single window completed at edge k with Enable then dropped to 0 -> ValidOut=1 exactly at edge k+2, then 0; no further outputs while stalled.
- Enable toggling every 400 ns with random pixels -> output sequence identical to the Enable-always-1 run, only time-shifted; count still 36.
- RST pulse mid-frame (row 4, col 3) -> outputs 0 immediately (async), no FrameDone; a fresh 8x8 frame afterwards yields 36 valid outputs and one FrameDone.
